// File: rtl/fifo_status.sv
// rtl/fifo_status.sv - Async FIFO side status: registered level, empty/full, almost and sticky misuse flags.
// MODE 0 lives in the read domain (empty side), MODE 1 in the write domain (full side).
module fifo_status #(
    parameter int MODE       = 0,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH:0]   i_ptr_lc,
    input  logic [ADDR_WIDTH:0]   i_ptr_rmt,
    input  logic                  i_op,
    input  logic [ADDR_WIDTH:0]   i_thresh,
    input  logic                  i_err_clr,
    output logic                  o_flag,
    output logic                  o_almost,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    generate
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("fifo_status: MODE must be 0 or 1");
        end
        if (ADDR_WIDTH < 2) begin : g_bad_width
            $error("fifo_status: ADDR_WIDTH must be at least 2");
        end
    endgenerate

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] r_ptr_rmt;
    logic [ADDR_WIDTH:0] r_level;
    logic                r_flag;
    logic                r_almost;
    logic                r_err;

    logic [ADDR_WIDTH:0] w_lc_bin;
    logic [ADDR_WIDTH:0] w_rmt_bin;
    logic [ADDR_WIDTH:0] w_diff;
    logic                w_illegal;
    logic                w_flag_nxt;
    logic                w_almost_nxt;
    logic                w_err_set;

    assign w_lc_bin  = gray2bin(i_ptr_lc);
    assign w_rmt_bin = gray2bin(r_ptr_rmt);

    generate
        if (MODE == 1) begin : g_wr
            assign w_diff       = w_lc_bin - w_rmt_bin;
            // Full tested directly on Gray codes: equal except the top two bits inverted.
            assign w_flag_nxt   = (i_ptr_lc == {~r_ptr_rmt[ADDR_WIDTH:ADDR_WIDTH-1],
                                                r_ptr_rmt[ADDR_WIDTH-2:0]});
            assign w_almost_nxt = (i_thresh <= DEPTH) && (w_diff >= i_thresh);
            // A zero threshold means almost_full is permanently true, including in reset.
            assign o_almost     = r_almost | (i_thresh == '0);
        end else begin : g_rd
            assign w_diff       = w_rmt_bin - w_lc_bin;
            assign w_flag_nxt   = (w_diff == '0);
            assign w_almost_nxt = (i_thresh >= DEPTH) || (w_diff <= i_thresh);
            assign o_almost     = r_almost;
        end
    endgenerate

    assign w_illegal = (w_diff > DEPTH);
    assign w_err_set = (i_op && r_flag) || w_illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr_rmt <= '0;
            r_level   <= '0;
            r_flag    <= (MODE == 0);
            r_almost  <= (MODE == 0);
            r_err     <= 1'b0;
        end else begin
            r_ptr_rmt <= i_ptr_rmt;
            // An impossible distance means a corrupted pointer; keep the last sane level.
            if (!w_illegal) begin
                r_level <= w_diff;
            end
            r_flag   <= w_flag_nxt;
            r_almost <= w_almost_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_flag  = r_flag;
    assign o_level = r_level;
    assign o_err   = r_err;

endmodule

// File: tb/tb_fifo_status.sv
// tb/tb_fifo_status.sv - Self-checking bench for fifo_status, both modes side by side against a count-based model.
module tb_fifo_status;

    logic clk;
    logic clk_en;
    logic rst_n;

    logic [1:0][4:0] ptr_lc;
    logic [1:0][4:0] ptr_rmt;
    logic [1:0][4:0] thresh;
    logic [1:0]      op;
    logic [1:0]      clr;
    logic [1:0]      flag;
    logic [1:0]      almost;
    logic [1:0]      err;
    logic [1:0][4:0] level;

    int total = 0;
    int bad   = 0;

    // Model state: binary word counts, one-cycle-old remote count, expected outputs.
    int              lc_cnt  [2];
    int              rmt_cnt [2];
    int              rmt_q   [2];
    logic [1:0]      e_flag;
    logic [1:0]      e_almost;
    logic [1:0]      e_err;
    logic [1:0][4:0] e_level;

    fifo_status #(.MODE(0), .ADDR_WIDTH(4)) u_rd (
        .i_clk(clk), .i_rst_n(rst_n), .i_ptr_lc(ptr_lc[0]), .i_ptr_rmt(ptr_rmt[0]),
        .i_op(op[0]), .i_thresh(thresh[0]), .i_err_clr(clr[0]),
        .o_flag(flag[0]), .o_almost(almost[0]), .o_level(level[0]), .o_err(err[0])
    );

    fifo_status #(.MODE(1), .ADDR_WIDTH(4)) u_wr (
        .i_clk(clk), .i_rst_n(rst_n), .i_ptr_lc(ptr_lc[1]), .i_ptr_rmt(ptr_rmt[1]),
        .i_op(op[1]), .i_thresh(thresh[1]), .i_err_clr(clr[1]),
        .o_flag(flag[1]), .o_almost(almost[1]), .o_level(level[1]), .o_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic apply();
        for (int m = 0; m < 2; m++) begin
            ptr_lc[m]  = gray(lc_cnt[m]);
            ptr_rmt[m] = gray(rmt_cnt[m]);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            rmt_q[m]   = 0;
            e_level[m] = 5'd0;
            e_err[m]   = 1'b0;
        end
        e_flag[0]   = 1'b1;
        e_almost[0] = 1'b1;
        e_flag[1]   = 1'b0;
        e_almost[1] = (thresh[1] == 5'd0);
    endtask

    task automatic model_step(input int m);
        int d;
        bit set;
        d   = (m == 0) ? ((rmt_q[m] - lc_cnt[m]) & 31) : ((lc_cnt[m] - rmt_q[m]) & 31);
        set = (op[m] && e_flag[m]) || (d > 16);
        e_err[m] = set ? 1'b1 : (clr[m] ? 1'b0 : e_err[m]);
        if (d <= 16) e_level[m] = d[4:0];
        e_flag[m] = (m == 0) ? (d == 0) : (d == 16);
        if (m == 0) e_almost[m] = (thresh[m] >= 16) || (d <= int'(thresh[m]));
        else if (thresh[m] == 0) e_almost[m] = 1'b1;
        else if (thresh[m] > 16) e_almost[m] = 1'b0;
        else e_almost[m] = (d >= int'(thresh[m]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int m = 0; m < 2; m++) model_step(m);
            for (int m = 0; m < 2; m++) rmt_q[m] = rmt_cnt[m];
        end
        #1;
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        rst_n  = 1'b1;
        for (int m = 0; m < 2; m++) begin
            lc_cnt[m] = 0; rmt_cnt[m] = 0; op[m] = 1'b0; clr[m] = 1'b0;
        end
        thresh[0] = 5'd4;
        thresh[1] = 5'd12;
        apply();
        #2 rst_n = 1'b0;
        #3;
        total++; if (flag[0] !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", flag[0]); end
        total++; if (almost[0] !== 1'b1)  begin bad++; $display("FAIL reset_aempty got=%b exp=1", almost[0]); end
        total++; if (level[0] !== 5'd0)   begin bad++; $display("FAIL reset_level0 got=%0d exp=0", level[0]); end
        total++; if (err[0] !== 1'b0)     begin bad++; $display("FAIL reset_err0 got=%b exp=0", err[0]); end
        total++; if (flag[1] !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b exp=0", flag[1]); end
        total++; if (almost[1] !== 1'b0)  begin bad++; $display("FAIL reset_afull got=%b exp=0", almost[1]); end
        total++; if (level[1] !== 5'd0)   begin bad++; $display("FAIL reset_level1 got=%0d exp=0", level[1]); end
        model_reset();
        #5 rst_n = 1'b1;
        #2 clk_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_fill();
        for (int k = 0; k <= 16; k++) begin
            lc_cnt[1] = k;
            apply();
            tick();
            total++; if (level[1] !== k[4:0])       begin bad++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, level[1], k); end
            total++; if (almost[1] !== (k >= 12))   begin bad++; $display("FAIL fill_almost k=%0d got=%b exp=%b", k, almost[1], (k >= 12)); end
            total++; if (flag[1] !== (k == 16))     begin bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, flag[1], (k == 16)); end
        end
    endtask

    task automatic test_wrap();
        lc_cnt[0] = 30; rmt_cnt[0] = 30;
        apply();
        tick(); tick();
        total++; if (level[0] !== 5'd0) begin bad++; $display("FAIL wrap_start_level got=%0d exp=0", level[0]); end
        rmt_cnt[0] = 33 % 32;
        apply();
        tick();
        total++; if (flag[0] !== 1'b1) begin bad++; $display("FAIL wrap_early_deassert got=%b exp=1", flag[0]); end
        tick();
        total++; if (level[0] !== 5'd3) begin bad++; $display("FAIL wrap_level got=%0d exp=3", level[0]); end
        total++; if (flag[0] !== 1'b0)  begin bad++; $display("FAIL wrap_empty got=%b exp=0", flag[0]); end
    endtask

    task automatic test_misuse();
        total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL misuse_pre got=%b exp=0", err[1]); end
        op[1] = 1'b1;
        tick();
        total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL misuse_set got=%b exp=1", err[1]); end
        clr[1] = 1'b1;
        tick();
        total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL misuse_set_wins got=%b exp=1", err[1]); end
        op[1] = 1'b0;
        tick();
        total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL misuse_clear got=%b exp=0", err[1]); end
        clr[1] = 1'b0;
    endtask

    task automatic test_inconsistency();
        lc_cnt[0] = 0; rmt_cnt[0] = 5;
        apply();
        tick(); tick();
        total++; if (level[0] !== 5'd5) begin bad++; $display("FAIL incons_pre_level got=%0d exp=5", level[0]); end
        rmt_cnt[0] = 20;
        apply();
        tick(); tick();
        total++; if (err[0] !== 1'b1)   begin bad++; $display("FAIL incons_err got=%b exp=1", err[0]); end
        total++; if (level[0] !== 5'd5) begin bad++; $display("FAIL incons_hold got=%0d exp=5", level[0]); end
        rmt_cnt[0] = 5;
        apply();
        tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL incons_clear got=%b exp=0", err[0]); end
    endtask

    task automatic test_midrun_reset();
        rst_n = 1'b0;
        #1;
        total++; if (flag[0] !== 1'b1)  begin bad++; $display("FAIL mrst_empty got=%b exp=1", flag[0]); end
        total++; if (level[0] !== 5'd0) begin bad++; $display("FAIL mrst_level got=%0d exp=0", level[0]); end
        total++; if (level[1] !== 5'd0) begin bad++; $display("FAIL mrst_level1 got=%0d exp=0", level[1]); end
        model_reset();
        #3 rst_n = 1'b1;
        tick();
        total++; if (level[0] !== 5'd0) begin bad++; $display("FAIL mrst_edge1_level got=%0d exp=0", level[0]); end
        total++; if (flag[0] !== 1'b1)  begin bad++; $display("FAIL mrst_edge1_empty got=%b exp=1", flag[0]); end
        tick();
        total++; if (level[0] !== 5'd5) begin bad++; $display("FAIL mrst_edge2_level got=%0d exp=5", level[0]); end
        total++; if (flag[0] !== 1'b0)  begin bad++; $display("FAIL mrst_edge2_empty got=%b exp=0", flag[0]); end
    endtask

    task automatic test_random();
        int occ;
        for (int it = 0; it < 400; it++) begin
            for (int m = 0; m < 2; m++) begin
                occ = (m == 0) ? ((rmt_cnt[m] - lc_cnt[m]) & 31) : ((lc_cnt[m] - rmt_cnt[m]) & 31);
                if (occ > 16) begin
                    rmt_cnt[m] = lc_cnt[m];
                end else begin
                    // Grow moves the writer, shrink the reader; which one is local depends on mode.
                    if (occ < 16 && $urandom_range(0, 2) == 0) begin
                        if (m == 0) rmt_cnt[m] = (rmt_cnt[m] + 1) & 31;
                        else        lc_cnt[m]  = (lc_cnt[m] + 1) & 31;
                    end
                    if (occ > 0 && $urandom_range(0, 2) == 0) begin
                        if (m == 0) lc_cnt[m]  = (lc_cnt[m] + 1) & 31;
                        else        rmt_cnt[m] = (rmt_cnt[m] + 1) & 31;
                    end
                    if ($urandom_range(0, 59) == 0) rmt_cnt[m] = $urandom_range(0, 31);
                end
                op[m]  = ($urandom_range(0, 3) == 0);
                clr[m] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) thresh[m] = 5'($urandom_range(0, 20));
            end
            apply();
            tick();
            for (int m = 0; m < 2; m++) begin
                total++; if (flag[m] !== e_flag[m])     begin bad++; $display("FAIL rand_flag m=%0d it=%0d got=%b exp=%b", m, it, flag[m], e_flag[m]); end
                total++; if (almost[m] !== e_almost[m]) begin bad++; $display("FAIL rand_almost m=%0d it=%0d got=%b exp=%b", m, it, almost[m], e_almost[m]); end
                total++; if (level[m] !== e_level[m])   begin bad++; $display("FAIL rand_level m=%0d it=%0d got=%0d exp=%0d", m, it, level[m], e_level[m]); end
                total++; if (err[m] !== e_err[m])       begin bad++; $display("FAIL rand_err m=%0d it=%0d got=%b exp=%b", m, it, err[m], e_err[m]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_misuse();
        test_inconsistency();
        test_midrun_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_status.md
# fifo_status

Parametrised status generator for one side of the asynchronous FIFO. It takes the local Gray pointer and the synchronised remote Gray pointer, converts both to binary, and produces a registered fill level. From that level it produces the exact flag (empty or full), a programmable almost flag, and a sticky error flag. It sits in the read domain (MODE 0) or the write domain (MODE 1) and adds almost-thresholds, fill level and misuse detection to the basic empty/full generator.

## Interface
- MODE, 0: 0 = read/empty side, 1 = write/full side; any other value is a elaboration-time error
- ADDR_WIDTH, 4: FIFO depth DEPTH = 2^ADDR_WIDTH; pointers and level are ADDR_WIDTH+1 bits

- clk  in  1  side clock (clk_rd for MODE 0, clk_wr for MODE 1)
- rst_n  in  1  asynchronous active-low reset
- ptr_lc  in  ADDR_WIDTH+1  local extended Gray pointer (read ptr in MODE 0, write ptr in MODE 1)
- ptr_rmt  in  ADDR_WIDTH+1  remote extended Gray pointer, already through the 2-FF synchroniser
- op  in  1  local pop (MODE 0) or push (MODE 1) issued this cycle
- thresh  in  ADDR_WIDTH+1  almost threshold, unsigned, quasi-static
- err_clr  in  1  synchronous clear of err
- flag  out  1  MODE 0: empty; MODE 1: full
- almost  out  1  MODE 0: almost_empty; MODE 1: almost_full
- level  out  ADDR_WIDTH+1  registered fill level in words, 0..DEPTH
- err  out  1  sticky: underflow/overflow attempt or pointer inconsistency

## Operation
- Stage 1: ptr_rmt_r <= ptr_rmt.
- Gray-to-binary conversion (combinational): b[N] = g[N]; b[i] = b[i+1] ^ g[i]. lc_bin comes from ptr_lc, rmt_bin from ptr_rmt_r.
- Level diff, modulo 2^(ADDR_WIDTH+1):
  - MODE 0: diff = rmt_bin - lc_bin (write minus read).
  - MODE 1: diff = lc_bin - rmt_bin.
- Stage 2 (all outputs registered):
  - level <= (diff > DEPTH) ? level : diff. An illegal diff holds the previous level.
  - MODE 0: flag <= (diff == 0); almost <= (diff <= thresh).
  - MODE 1: flag <= (diff == DEPTH); almost <= (diff >= thresh).
  - MODE 1 full is equivalent to the Gray test "local = remote with the top two bits inverted". Both forms must agree.
- err sets on any edge where either of these holds:
  - op && flag (pop while empty, or push while full), using the registered flag;
  - diff > DEPTH.
- err clears only on err_clr. If set and clear conditions occur in the same cycle, set wins.
- Threshold edge cases:
  - MODE 0, thresh ≥ DEPTH: almost is constantly 1.
  - MODE 1, thresh = 0: almost is constantly 1.
  - MODE 1, thresh > DEPTH: almost is never asserted.
- No internal state beyond ptr_rmt_r and the output registers. No FSM. Pointer wrap-around is handled entirely by the modular subtraction.

## Timing
- Reset values, all applied asynchronously on rst_n low:
  - ptr_rmt_r = 0; level = 0; err = 0.
  - MODE 0: flag = 1, almost = 1.
  - MODE 1: flag = 0, almost = 0 when thresh > 0.
- Reset release: behaviour resumes on the first clk edge with rst_n high. A reset mid-operation discards ptr_rmt_r, and flag/level reflect the inputs two edges after release.
- Latency:
  - ptr_lc change → outputs: 1 clk edge.
  - ptr_rmt change → outputs: 2 clk edges.
  - op → err: 1 edge.
  - thresh change → almost: 1 edge.
- Pessimism: flags may stay asserted for up to 2 cycles (plus synchroniser delay) after the remote side moves. They must never deassert early.
- Simultaneous local and remote movement in one cycle: level reflects the net diff, with no special casing.

## Test plan
- Reset, ADDR_WIDTH=4, MODE 0: assert rst_n low with no clock running → flag=1, almost=1, level=0, err=0 immediately.
- MODE 1 fill: hold ptr_rmt=0 and step ptr_lc Gray through 0..16, with thresh=12 →
  - almost rises one edge after ptr_lc = Gray(12);
  - flag rises one edge after ptr_lc = Gray(16) = 5'b11000;
  - level tracks 0..16.
- Wrap-around, MODE 0: set ptr_lc = Gray(30), then step ptr_rmt from Gray(30) to Gray(33 mod 32 = 1) → level = 3 two edges after ptr_rmt settles; flag falls on the same edge.
- Misuse: MODE 1 with full asserted, pulse op for one cycle → err=1 on the next edge. Pulse err_clr while op is still high → err stays 1. Pulse err_clr with op low → err=0.
- Inconsistency: MODE 0, ptr_lc = Gray(0), ptr_rmt = Gray(20) → err=1 and level holds its prior value.
- Mid-run reset: MODE 0 at level=5, pulse rst_n low for half a cycle → flag=1 and level=0 at once; level returns to 5 two edges after release.
